// File: rtl/ksa_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ksa_pkg
// Brief   : Shared state encoding and defaults for the RC4 key-schedule swap FSM.
// Revision: 1.0
// ============================================================================
package ksa_pkg;

    localparam int KEY_LEN_DEFAULT = 3;

    // Bit 4 is the write strobe and bit 3 the finish pulse, so both outputs
    // come straight from a state flop.
    typedef enum logic [4:0] {
        IDLE  = 5'b00_000,
        RD_I  = 5'b00_001,
        GET_I = 5'b00_010,
        RD_J  = 5'b00_011,
        GET_J = 5'b00_100,
        NEXT  = 5'b00_101,
        WR_I  = 5'b10_000,
        WR_J  = 5'b10_001,
        DONE  = 5'b01_000
    } state_e;

endpackage
`default_nettype wire

// File: rtl/key_byte_sel.sv
`default_nettype none
// ============================================================================
// Module  : key_byte_sel
// Brief   : Combinational select of key byte k; byte 0 is the most-significant.
// Revision: 1.0
// ============================================================================
module key_byte_sel #(
    parameter int KEY_LEN = 3,
    parameter int K_W     = 2
) (
    input  logic [8*KEY_LEN-1:0] key,
    input  logic [K_W-1:0]       k,
    output logic [7:0]           key_byte
);

    always_comb begin
        key_byte = '0;
        for (int idx = 0; idx < KEY_LEN; idx++) begin
            if (int'(k) == idx) begin
                key_byte = key[8*(KEY_LEN-1-idx) +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ksa_swap_fsm.sv
`default_nettype none
// ============================================================================
// Module  : ksa_swap_fsm
// Brief   : RC4 key-scheduling pass over an external 256-byte S-memory.
// Revision: 1.0
// ============================================================================
module ksa_swap_fsm
    import ksa_pkg::*;
#(
    parameter int KEY_LEN = KEY_LEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [8*KEY_LEN-1:0] secret_key,
    input  logic [7:0]           rd_data,
    output logic [7:0]           mem_addr,
    output logic [7:0]           wr_data,
    output logic                 wr_en,
    output logic                 finish
);

    localparam int K_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [K_W-1:0] C_K_LAST = K_W'(KEY_LEN - 1);

    state_e               state_q, state_d;
    logic [7:0]           i_q, i_d;
    logic [7:0]           j_q, j_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [7:0]           si_q, si_d;
    logic [7:0]           sj_q, sj_d;
    logic [8*KEY_LEN-1:0] key_q, key_d;
    logic [7:0]           mem_addr_q, mem_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic [7:0]           w_key_byte;

    key_byte_sel #(
        .KEY_LEN (KEY_LEN),
        .K_W     (K_W)
    ) u_key_byte_sel (
        .key      (key_q),
        .k        (k_q),
        .key_byte (w_key_byte)
    );

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        si_d       = si_q;
        sj_d       = sj_q;
        key_d      = key_q;
        mem_addr_d = '0;
        wr_data_d  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_I;
                    key_d   = secret_key;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            RD_I:  state_d = GET_I;
            GET_I: begin
                si_d    = rd_data;
                j_d     = j_q + rd_data + w_key_byte;
                state_d = RD_J;
            end
            RD_J:  state_d = GET_J;
            GET_J: begin
                sj_d    = rd_data;
                state_d = WR_I;
            end
            WR_I:  state_d = WR_J;
            WR_J:  state_d = NEXT;
            NEXT: begin
                if (i_q == 8'hFF) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    k_d     = (k_q == C_K_LAST) ? '0 : k_q + K_W'(1);
                    state_d = RD_I;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are staged for the state being entered so they are registered.
        case (state_d)
            RD_I:    mem_addr_d = i_d;
            RD_J:    mem_addr_d = j_d;
            WR_I: begin
                mem_addr_d = i_d;
                wr_data_d  = sj_d;
            end
            WR_J: begin
                mem_addr_d = j_d;
                wr_data_d  = si_d;
            end
            default: begin
                mem_addr_d = '0;
                wr_data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            si_q       <= '0;
            sj_q       <= '0;
            key_q      <= '0;
            mem_addr_q <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            key_q      <= key_d;
            mem_addr_q <= mem_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_en    = state_q[4];
    assign finish   = state_q[3];

endmodule
`default_nettype wire

// File: tb/tb_ksa_swap_fsm.sv
`default_nettype none
// ============================================================================
// Module  : tb_ksa_swap_fsm
// Brief   : Scoreboard bench with a behavioural RC4 KSA model and a sync S-RAM.
// Revision: 1.0
// ============================================================================
module tb_ksa_swap_fsm;

    localparam int KL = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [8*KL-1:0] secret_key;
    logic [7:0]    rd_data;
    logic [7:0]    mem_addr;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          finish;

    logic [7:0]    ram   [256];
    logic [7:0]    ref_s [256];
    logic          init_req;
    logic [15:0]   exp_wr_q [$];
    logic [15:0]   act_wr_q [$];
    int            exp_fin_q [$];
    int            cyc = 0;
    int            finish_cnt = 0;
    int            n_chk = 0;
    int            n_pass = 0;

    ksa_swap_fsm #(.KEY_LEN(KL)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .secret_key (secret_key),
        .rd_data    (rd_data),
        .mem_addr   (mem_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .finish     (finish)
    );

    always #5 clk = ~clk;

    // Synchronous S-memory, one-cycle read latency, with an identity-fill request.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (init_req) begin
            for (int a = 0; a < 256; a++) ram[a] <= 8'(a);
        end else if (wr_en) begin
            ram[mem_addr] <= wr_data;
        end
        rd_data <= ram[mem_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      nm, act, act, exp, exp, cyc);
    endtask

    // Monitor: every write strobe and finish pulse is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                act_wr_q.push_back({mem_addr, wr_data});
                if (exp_wr_q.size() == 0) chk("unexpected_write", int'({mem_addr, wr_data}), -1);
                else chk("write_addr_data", int'({mem_addr, wr_data}), int'(exp_wr_q.pop_front()));
            end
            if (finish) begin
                finish_cnt++;
                if (exp_fin_q.size() == 0) chk("unexpected_finish", cyc, -1);
                else chk("finish_cycle", cyc, exp_fin_q.pop_front());
            end
        end
    end

    task automatic reinit();
        init_req = 1'b1;
        @(posedge clk); #1;
        init_req = 1'b0;
        for (int a = 0; a < 256; a++) ref_s[a] = 8'(a);
    endtask

    // Golden RC4 key schedule; emits the two expected writes per index.
    task automatic model_pass(input logic [8*KL-1:0] key);
        int j;
        logic [7:0] t;
        logic [7:0] kb;
        j = 0;
        for (int i = 0; i < 256; i++) begin
            kb = key[8*KL-1-8*(i%KL) -: 8];
            j = (j + int'(ref_s[i]) + int'(kb)) % 256;
            exp_wr_q.push_back({8'(i), ref_s[j]});
            exp_wr_q.push_back({8'(j), ref_s[i]});
            t = ref_s[i];
            ref_s[i] = ref_s[j];
            ref_s[j] = t;
        end
    endtask

    task automatic start_pass(output int s);
        s = cyc + 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic to_edge(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_fin(input int target);
        int n;
        n = 0;
        while (finish_cnt < target && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("finish_count", finish_cnt, target);
    endtask

    task automatic check_mem();
        int bad;
        int distinct;
        bit seen [256];
        bad = 0;
        distinct = 0;
        for (int a = 0; a < 256; a++) seen[a] = 1'b0;
        for (int a = 0; a < 256; a++) begin
            if (ram[a] !== ref_s[a]) bad++;
            seen[ram[a]] = 1'b1;
        end
        for (int a = 0; a < 256; a++) if (seen[a]) distinct++;
        chk("final_s_mismatches", bad, 0);
        chk("final_s_distinct", distinct, 256);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_wr_en"},    int'(wr_en),    0);
        chk({tag, "_finish"},   int'(finish),   0);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_wr_data"},  int'(wr_data),  0);
    endtask

    initial begin
        int s;
        logic [15:0] k249 [6];
        logic [15:0] kff  [4];
        logic [8*KL-1:0] k1;
        logic [8*KL-1:0] k2;
        k249 = '{16'h0000, 16'h0000, 16'h0103, 16'h0301, 16'h024E, 16'h4E02};
        kff  = '{16'h00FF, 16'hFF00, 16'h0100, 16'hFF01};

        rst = 1'b1;
        start = 1'b1;
        secret_key = '0;
        init_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        start = 1'b0;
        rst = 1'b0;

        // Directed key 0x000249
        reinit();
        secret_key = 24'h000249;
        model_pass(secret_key);
        act_wr_q.delete();
        start_pass(s);
        exp_fin_q.push_back(s + 1792);
        wait_fin(1);
        chk("wr_count_000249", act_wr_q.size(), 512);
        for (int n = 0; n < 6; n++)
            if (n < act_wr_q.size()) chk("first_writes_000249", int'(act_wr_q[n]), int'(k249[n]));
        check_mem();
        check_idle_outputs("done_000249");

        // Directed key 0xFFFFFF: j wraps
        reinit();
        secret_key = 24'hFFFFFF;
        model_pass(secret_key);
        act_wr_q.delete();
        start_pass(s);
        exp_fin_q.push_back(s + 1792);
        wait_fin(2);
        chk("wr_count_ffffff", act_wr_q.size(), 512);
        for (int n = 0; n < 4; n++)
            if (n < act_wr_q.size()) chk("first_writes_ffffff", int'(act_wr_q[n]), int'(kff[n]));
        check_mem();

        // Random key with start pulses during GET_J and DONE
        reinit();
        secret_key = 24'($urandom);
        model_pass(secret_key);
        act_wr_q.delete();
        start_pass(s);
        exp_fin_q.push_back(s + 1792);
        to_edge(s + 3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        to_edge(s + 1792);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_fin(3);
        chk("wr_count_pulsed", act_wr_q.size(), 512);
        check_mem();

        // Start held through DONE chains a second pass over the permuted S
        reinit();
        k1 = 24'($urandom);
        k2 = 24'($urandom);
        secret_key = k1;
        model_pass(k1);
        model_pass(k2);
        act_wr_q.delete();
        start_pass(s);
        exp_fin_q.push_back(s + 1792);
        exp_fin_q.push_back(s + 1794 + 1792);
        to_edge(s + 100);
        secret_key = k2;
        to_edge(s + 1790);
        start = 1'b1;
        to_edge(s + 1794);
        start = 1'b0;
        wait_fin(5);
        chk("wr_count_chained", act_wr_q.size(), 1024);
        check_mem();

        // Reset mid-pass aborts, then a fresh pass completes
        reinit();
        secret_key = 24'($urandom);
        model_pass(secret_key);
        start_pass(s);
        exp_fin_q.push_back(s + 1792);
        to_edge(s + 500);
        rst = 1'b1;
        exp_wr_q.delete();
        exp_fin_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("abort");
        repeat (20) begin
            @(posedge clk); #1;
        end
        chk("finish_count_abort", finish_cnt, 5);
        reinit();
        secret_key = 24'($urandom);
        model_pass(secret_key);
        act_wr_q.delete();
        start_pass(s);
        exp_fin_q.push_back(s + 1792);
        wait_fin(6);
        chk("wr_count_after_abort", act_wr_q.size(), 512);
        check_mem();

        chk("pending_writes", exp_wr_q.size(), 0);
        chk("pending_finish", exp_fin_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ksa_swap_fsm.md
KSA_SWAP_FSM -- requirements
Module: ksa_swap_fsm

Interface
REQ-001 Parameter KEY_LEN, default 3: number of secret-key bytes cycled over by the key index.
REQ-002 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous, active-high.
REQ-004 Port start, input, 1: begin the key-scheduling pass; sampled only in IDLE.
REQ-005 Port secret_key, input, 8*KEY_LEN: key bytes; byte 0 = most-significant byte.
REQ-006 Port rd_data, input, 8: S-memory read data; valid the cycle after mem_addr is presented.
REQ-007 Port mem_addr, output, 8: S-memory address.
REQ-008 Port wr_data, output, 8: S-memory write data.
REQ-009 Port wr_en, output, 1: S-memory write strobe, one cycle per write.
REQ-010 Port finish, output, 1: one-cycle pulse when the pass completes.

Function
REQ-011 The block SHALL run after memory init (S[i]=i) and, for i=0..255: j = j + S[i] + key[i mod KEY_LEN], then swap S[i] and S[j].
REQ-012 States: IDLE, RD_I, GET_I, RD_J, GET_J, WR_I, WR_J, NEXT, DONE.
REQ-013 IDLE -> RD_I when start=1; else stay in IDLE. On leaving IDLE, secret_key SHALL be latched, and i, j and the key index k SHALL be cleared to 0.
REQ-014 RD_I: mem_addr=i, then -> GET_I.
REQ-015 GET_I: si<=rd_data; j<=(j+rd_data+key byte k) mod 256, with 8-bit wrap and the carry discarded; then -> RD_J.
REQ-016 RD_J: mem_addr=j (the updated value), then -> GET_J.
REQ-017 GET_J: sj<=rd_data, then -> WR_I.
REQ-018 WR_I: mem_addr=i, wr_data=sj, wr_en=1, then -> WR_J.
REQ-019 WR_J: mem_addr=j, wr_data=si, wr_en=1, then -> NEXT.
REQ-020 NEXT: if i==255 -> DONE; else i<=i+1, k<=(k==KEY_LEN-1)?0:k+1, -> RD_I.
REQ-021 DONE: finish=1 for exactly one cycle, then -> IDLE.
REQ-022 Cost per index SHALL be 7 cycles; finish SHALL be high in the cycle 1792 edges after the edge that sampled start.
REQ-023 When i==j, both writes SHALL store the same value, leaving S[i] unchanged.
REQ-024 start SHALL be ignored in every state except IDLE.
REQ-025 wr_en SHALL be 0 in every state except WR_I and WR_J.
REQ-026 mem_addr and wr_data SHALL be 0 in IDLE and DONE.
REQ-027 wr_en and finish SHALL be decoded from dedicated state-encoding bits, so they are glitch-free.
REQ-028 k SHALL use a wrap counter, not a modulo operator.

Reset
REQ-029 rst=1 SHALL force IDLE and set i=j=k=si=sj=0 at the next rising edge, overriding all transitions including start.
REQ-030 Reset values: wr_en=0, finish=0, mem_addr=0, wr_data=0.
REQ-031 Reset mid-pass SHALL abort with no further writes; memory contents are not restored, and a new start restarts at i=0.

Structure
REQ-032 Shared package ksa_pkg SHALL hold the state enum typedef and KEY_LEN_DEFAULT=3.
REQ-033 One sub-module, key_byte_sel, SHALL select byte k of the latched key combinationally.
REQ-034 The S-memory itself SHALL be external to this block; the init FSM and this block share it through an upstream address/data mux.

Verification
REQ-035 Bench model: synchronous RAM preloaded with S[i]=i and 1-cycle read latency.
REQ-036 Key 24'h000249, start: i=0 gives j=0, a no-op swap with two writes of 0 to address 0; i=1 gives j=3, so S[1]=3 and S[3]=1; i=2 gives j=0x4E, so S[2]=0x4E and S[0x4E]=2.
REQ-037 Key 24'hFFFFFF, start: i=0 gives j=0xFF, so S[0]=0xFF and S[0xFF]=0; i=1 gives j=0xFF (wrap), so S[1]=0 and S[0xFF]=1.
REQ-038 Any key, start: finish pulses exactly once, 1792 cycles after start is sampled; 512 wr_en cycles total; final S is a permutation of 0..255 matching a golden RC4 KSA model.
REQ-039 Assert rst during cycle 500 of a pass: next cycle is IDLE with wr_en=0 and finish=0; a new start completes a full 1792-cycle pass.
REQ-040 Pulse start during GET_J and during DONE: no effect on sequence or timing; start held high through DONE begins a second pass from i=0.
